// File: rtl/pixel_frame_loader_pkg.sv
// Shared constants, row type and read-FSM states for the MNIST pixel front end.
package pixel_frame_loader_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int ROW_AW = 5;
    localparam int FCNT_W = 8;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int RAM_AW = ROW_AW + 1;

    typedef logic [IMG_W-1:0] row_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    // Bank bit is the MSB so each bank occupies one contiguous half of the RAM.
    function automatic logic [RAM_AW-1:0] ram_addr(input logic bank, input logic [ROW_AW-1:0] row);
        return {bank, row};
    endfunction
endpackage

// File: rtl/pixel_frame_loader_if.sv
// Row stream from the frame loader to the first network layer (valid/ready).
interface pixel_frame_loader_if;
    import pixel_frame_loader_pkg::*;

    row_t              row_data;
    logic [ROW_AW-1:0] row_idx;
    logic              row_valid;
    logic              row_ready;
    logic              frame_last;

    modport master (output row_data, output row_idx, output row_valid, output frame_last, input row_ready);
    modport slave  (input row_data, input row_idx, input row_valid, input frame_last, output row_ready);
endinterface

// File: rtl/pixel_frame_loader_frame_bank_ram.sv
// Two-bank row store: one write port, one registered read port (distributed RAM).
module frame_bank_ram
    import pixel_frame_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_waddr,
    input  row_t              i_wdata,
    input  logic              i_re,
    input  logic [RAM_AW-1:0] i_raddr,
    output row_t              o_rdata
);
    row_t r_mem [0:(2**RAM_AW)-1];
    row_t r_rdata;

    // Row write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= {IMG_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/pixel_frame_loader.sv
// Packs 1-bit raster pixels into rows, double-buffers frames and streams rows out.
module pixel_frame_loader
    import pixel_frame_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_data_in,
    input  logic                 i_valid_in,
    pixel_frame_loader_if.master rows,
    output logic [FCNT_W-1:0]    o_frame_count,
    output logic                 o_overflow
);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(IMG_H - 1);
    localparam logic [ROW_AW-1:0] ROW_ONE   = ROW_AW'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    logic [COL_W-1:0]  r_col_cnt;
    logic [ROW_AW-1:0] r_row_cnt;
    row_t              r_shift_row;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_full;
    logic              r_overflow;
    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic [ROW_AW-1:0] r_row_idx;
    logic              r_row_valid;
    logic              r_frame_last;
    logic [FCNT_W-1:0] r_frame_count;

    logic              w_accept;
    logic              w_row_end;
    logic              w_frame_end;
    logic              w_handshake;
    logic              w_frame_done;
    logic              w_rd_en;
    logic [ROW_AW-1:0] w_rd_row;
    row_t              w_wr_row;
    row_t              w_rd_data;
    logic [1:0]        w_set_full;
    logic [1:0]        w_clr_full;

    assign w_accept    = i_valid_in & ~r_full[r_wr_bank];
    assign w_row_end   = w_accept & (r_col_cnt == LAST_COL);
    assign w_frame_end = w_row_end & (r_row_cnt == LAST_ROW);
    // The final column bit is merged on the fly so the row is written in the same cycle.
    assign w_wr_row    = {i_data_in, r_shift_row[IMG_W-2:0]};
    assign w_handshake = r_row_valid & rows.row_ready;
    assign w_set_full  = w_frame_end  ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_full  = w_frame_done ? (2'b01 << r_rd_bank) : 2'b00;

    // Write side: pixel packing, write counters, bank flags and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_cnt   <= {COL_W{1'b0}};
            r_row_cnt   <= {ROW_AW{1'b0}};
            r_shift_row <= {IMG_W{1'b0}};
            r_wr_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift_row[r_col_cnt] <= i_data_in;
                if (w_row_end) begin
                    r_col_cnt <= {COL_W{1'b0}};
                    if (w_frame_end) begin
                        r_row_cnt <= {ROW_AW{1'b0}};
                        r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_row_cnt <= r_row_cnt + ROW_ONE;
                    end
                end else begin
                    r_col_cnt <= r_col_cnt + COL_ONE;
                end
            end
            if (i_valid_in & r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end
            r_full <= (r_full | w_set_full) & ~w_clr_full;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next state; PRIME gives the documented two-cycle first-row latency.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_en      = 1'b0;
        w_rd_row     = r_row_idx;
        w_frame_done = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = RD_PRIME;
                end else begin
                    w_state_nxt = RD_IDLE;
                end
            end
            RD_PRIME: begin
                w_state_nxt = RD_STREAM;
                w_rd_en     = 1'b1;
                w_rd_row    = {ROW_AW{1'b0}};
            end
            RD_STREAM: begin
                if (w_handshake && (r_row_idx == LAST_ROW)) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = RD_IDLE;
                end else if (w_handshake) begin
                    w_rd_en  = 1'b1;
                    w_rd_row = r_row_idx + ROW_ONE;
                end else begin
                    w_state_nxt = RD_STREAM;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Row stream sideband registers and delivered-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_idx     <= {ROW_AW{1'b0}};
            r_row_valid   <= 1'b0;
            r_frame_last  <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_frame_count <= {FCNT_W{1'b0}};
        end else if (w_rd_en) begin
            r_row_idx    <= w_rd_row;
            r_row_valid  <= 1'b1;
            r_frame_last <= (w_rd_row == LAST_ROW);
        end else if (w_frame_done) begin
            r_row_idx     <= {ROW_AW{1'b0}};
            r_row_valid   <= 1'b0;
            r_frame_last  <= 1'b0;
            r_rd_bank     <= ~r_rd_bank;
            r_frame_count <= r_frame_count + FCNT_ONE;
        end
    end

    frame_bank_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_row_end),
        .i_waddr (ram_addr(r_wr_bank, r_row_cnt)),
        .i_wdata (w_wr_row),
        .i_re    (w_rd_en),
        .i_raddr (ram_addr(r_rd_bank, w_rd_row)),
        .o_rdata (w_rd_data)
    );

    assign rows.row_data   = w_rd_data;
    assign rows.row_idx    = r_row_idx;
    assign rows.row_valid  = r_row_valid;
    assign rows.frame_last = r_frame_last;
    assign o_frame_count   = r_frame_count;
    assign o_overflow      = r_overflow;
endmodule

// File: tb/tb_pixel_frame_loader.sv
// Bench for pixel_frame_loader: golden-row table plus a frame-queue reference model.
module tb_pixel_frame_loader;
    import pixel_frame_loader_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;
    typedef logic [NPIX-1:0] frame_t;

    typedef struct {
        int   r_lo;
        int   r_hi;
        int   c_lo;
        int   c_hi;
        row_t exp_row;
    } band_t;

    typedef struct {
        int   c_lo;
        int   c_hi;
        row_t exp_row;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              data_in;
    logic              valid_in;
    logic [FCNT_W-1:0] frame_count;
    logic              overflow;

    pixel_frame_loader_if rows_if ();

    pixel_frame_loader dut (
        .clk           (clk),
        .rst           (rst),
        .i_data_in     (data_in),
        .i_valid_in    (valid_in),
        .rows          (rows_if),
        .o_frame_count (frame_count),
        .o_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: completed-but-undelivered frames in a queue, in arrival order.
    frame_t            pend_q[$];
    frame_t            cur;
    int                pix_cnt;
    int                exp_row;
    logic [FCNT_W-1:0] exp_fc;
    logic              exp_ov;
    int                hs_total;
    row_t              got_rows[$];
    logic              got_last[$];

    logic              m_rv, m_rr, m_fl, m_acc, m_hs, prev_stall;
    row_t              m_rd, prev_data;
    logic [ROW_AW-1:0] m_ri, prev_idx;
    frame_t            m_front;

    band_t bands[9];
    vec_t  vec[IMG_H];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t got_row(input int r);
        if (r < got_rows.size()) return got_rows[r];
        return {IMG_W{1'bx}};
    endfunction

    function automatic logic got_lst(input int r);
        if (r < got_last.size()) return got_last[r];
        return 1'bx;
    endfunction

    // Monitor: evaluates, half a cycle early, what the coming rising edge will do.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
                cur        = '0;
                pix_cnt    = 0;
                exp_row    = 0;
                exp_fc     = '0;
                exp_ov     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                m_rv = rows_if.row_valid;
                m_rr = rows_if.row_ready;
                m_rd = rows_if.row_data;
                m_ri = rows_if.row_idx;
                m_fl = rows_if.frame_last;
                chk("frame_count", {56'd0, frame_count}, {56'd0, exp_fc});
                chk("overflow", {63'd0, overflow}, {63'd0, exp_ov});
                if (prev_stall) begin
                    chk("stall_valid", {63'd0, m_rv}, 64'd1);
                    chk("stall_data", {36'd0, m_rd}, {36'd0, prev_data});
                    chk("stall_idx", {59'd0, m_ri}, {59'd0, prev_idx});
                end
                if (pend_q.size() == 0) begin
                    chk("idle_row_valid", {63'd0, m_rv}, 64'd0);
                end else if (exp_row != 0) begin
                    chk("mid_frame_valid", {63'd0, m_rv}, 64'd1);
                end
                m_acc = valid_in && (pend_q.size() < 2);
                m_hs  = m_rv && m_rr;
                if (m_hs && pend_q.size() > 0) begin
                    m_front = pend_q[0];
                    chk("row_data", {36'd0, m_rd}, {36'd0, m_front[exp_row*IMG_W +: IMG_W]});
                    chk("row_idx", {59'd0, m_ri}, 64'(exp_row));
                    chk("frame_last", {63'd0, m_fl}, {63'd0, (exp_row == IMG_H-1)});
                    got_rows.push_back(m_rd);
                    got_last.push_back(m_fl);
                    hs_total++;
                    exp_row++;
                    if (exp_row == IMG_H) begin
                        void'(pend_q.pop_front());
                        exp_row = 0;
                        exp_fc  = exp_fc + 8'd1;
                    end
                end
                prev_stall = m_rv && !m_rr;
                prev_data  = m_rd;
                prev_idx   = m_ri;
                if (valid_in) begin
                    if (!m_acc) begin
                        exp_ov = 1'b1;
                    end else begin
                        cur[pix_cnt] = data_in;
                        pix_cnt++;
                        if (pix_cnt == NPIX) begin
                            pend_q.push_back(cur);
                            pix_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_row_valid"}, {63'd0, rows_if.row_valid}, 64'd0);
        chk({tag, "_row_data"}, {36'd0, rows_if.row_data}, 64'd0);
        chk({tag, "_row_idx"}, {59'd0, rows_if.row_idx}, 64'd0);
        chk({tag, "_frame_last"}, {63'd0, rows_if.frame_last}, 64'd0);
        chk({tag, "_frame_count"}, {56'd0, frame_count}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    // Sends the golden digit; duty < 100 inserts random idle cycles between pixels.
    task automatic send_table(input int duty, input string tag);
        for (int p = 0; p < NPIX; p++) begin
            while (duty < 100 && $urandom_range(0, 99) >= duty) begin
                valid_in = 1'b0;
                cycle();
            end
            valid_in = 1'b1;
            data_in  = (vec[p / IMG_W].c_lo <= p % IMG_W) && (p % IMG_W <= vec[p / IMG_W].c_hi);
            cycle();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
        cycle();
        chk({tag, "_lat_plus1"}, {63'd0, rows_if.row_valid}, 64'd0);
        cycle();
        chk({tag, "_lat_plus2"}, {63'd0, rows_if.row_valid}, 64'd1);
    endtask

    task automatic send_random(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            valid_in = 1'b1;
            data_in  = 1'($urandom_range(0, 1));
            cycle();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic drain(input int limit, input bit toggle, input string tag);
        for (int i = 0; i < limit && pend_q.size() != 0; i++) begin
            if (toggle) rows_if.row_ready = ~rows_if.row_ready;
            cycle();
        end
        chk({tag, "_drained"}, 64'(pend_q.size()), 64'd0);
    endtask

    task automatic check_golden(input string tag);
        chk({tag, "_rows_delivered"}, 64'(got_rows.size()), 64'(IMG_H));
        for (int r = 0; r < IMG_H; r++) begin
            chk({tag, "_golden_row"}, {36'd0, got_row(r)}, {36'd0, vec[r].exp_row});
            chk({tag, "_golden_last"}, {63'd0, got_lst(r)}, {63'd0, (r == IMG_H-1)});
        end
    endtask

    initial begin
        int hs0;
        n_checks = 0;
        n_fail   = 0;
        hs_total = 0;
        rst      = 1'b1;
        data_in  = 1'b0;
        valid_in = 1'b0;
        rows_if.row_ready = 1'b0;

        // Digit "7": spans of set columns per band of rows, with hand-computed row words.
        bands[0] = '{0, 3, 31, 0, 28'h0000000};
        bands[1] = '{4, 5, 3, 24, 28'h1FFFFF8};
        bands[2] = '{6, 9, 20, 23, 28'h0F00000};
        bands[3] = '{10, 13, 16, 19, 28'h00F0000};
        bands[4] = '{14, 17, 12, 15, 28'h000F000};
        bands[5] = '{18, 23, 8, 11, 28'h0000F00};
        bands[6] = '{24, 25, 31, 0, 28'h0000000};
        bands[7] = '{26, 26, 0, 0, 28'h0000001};
        bands[8] = '{27, 27, 27, 27, 28'h8000000};
        for (int b = 0; b < 9; b++) begin
            for (int r = bands[b].r_lo; r <= bands[b].r_hi; r++) begin
                vec[r] = '{bands[b].c_lo, bands[b].c_hi, bands[b].exp_row};
            end
        end

        repeat (3) cycle();
        check_reset_outs("reset");
        rst = 1'b0;
        cycle();

        // Known digit at full throughput.
        got_rows.delete(); got_last.delete();
        rows_if.row_ready = 1'b1;
        send_table(100, "s1");
        drain(200, 1'b0, "s1");
        check_golden("s1");
        chk("s1_frame_count", {56'd0, frame_count}, 64'd1);
        chk("s1_overflow", {63'd0, overflow}, 64'd0);

        // Checkerboard with row_ready toggling every cycle.
        got_rows.delete(); got_last.delete();
        hs0 = hs_total;
        for (int p = 0; p < NPIX; p++) begin
            valid_in = 1'b1;
            data_in  = ((p / IMG_W + p % IMG_W) % 2) == 1;
            rows_if.row_ready = ~rows_if.row_ready;
            cycle();
        end
        valid_in = 1'b0;
        drain(300, 1'b1, "s2");
        chk("s2_handshakes", 64'(hs_total - hs0), 64'(IMG_H));
        chk("s2_row0", {36'd0, got_row(0)}, {36'd0, 28'hAAAAAAA});
        chk("s2_row1", {36'd0, got_row(1)}, {36'd0, 28'h5555555});
        chk("s2_row27", {36'd0, got_row(27)}, {36'd0, 28'h5555555});
        chk("s2_frame_count", {56'd0, frame_count}, 64'd2);

        // Same digit with sparse valid_in.
        got_rows.delete(); got_last.delete();
        rows_if.row_ready = 1'b1;
        send_table(25, "s4");
        drain(200, 1'b0, "s4");
        check_golden("s4");
        chk("s4_frame_count", {56'd0, frame_count}, 64'd3);

        // Two random frames back to back at full throughput.
        hs0 = hs_total;
        send_random(2 * NPIX);
        drain(200, 1'b0, "s6");
        chk("s6_handshakes", 64'(hs_total - hs0), 64'(2 * IMG_H));
        chk("s6_frame_count", {56'd0, frame_count}, 64'd5);

        // Both banks filled while stalled; the third frame's first bit overflows.
        rows_if.row_ready = 1'b0;
        cycle();
        send_random(2 * NPIX);
        chk("s3_no_overflow_yet", {63'd0, overflow}, 64'd0);
        chk("s3_row_presented", {63'd0, rows_if.row_valid}, 64'd1);
        send_random(1);
        chk("s3_overflow_set", {63'd0, overflow}, 64'd1);
        hs0 = hs_total;
        rows_if.row_ready = 1'b1;
        drain(300, 1'b0, "s3");
        chk("s3_handshakes", 64'(hs_total - hs0), 64'(2 * IMG_H));
        chk("s3_frame_count", {56'd0, frame_count}, 64'd7);
        chk("s3_overflow_sticky", {63'd0, overflow}, 64'd1);

        // Reset in the middle of a frame, then a fresh frame.
        send_random(400);
        rst = 1'b1;
        #1;
        check_reset_outs("s5_rst_async");
        repeat (2) cycle();
        check_reset_outs("s5_rst_held");
        rst = 1'b0;
        cycle();
        got_rows.delete(); got_last.delete();
        send_table(100, "s5");
        drain(200, 1'b0, "s5");
        check_golden("s5");
        chk("s5_frame_count", {56'd0, frame_count}, 64'd1);
        chk("s5_overflow", {63'd0, overflow}, 64'd0);

        repeat (3) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
